grid_window_gen: RTL and testbench
==================================

// Module: grid_window_gen
// PURPOSE
//  Converts a raster-order 8-bit intensity stream into one 3x3 neighbourhood per interior pixel.
//  Packs each window on the 73-bit grid bus consumed by the edge-detect stage.
//  Two line buffers plus a 3x3 shift window; valid/ready on both sides.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line (>=3)
//  IMG_HEIGHT  480  lines per frame (>=3)
// PORTS
//  clk          in   1   clock
//  n_rst        in   1   reset, synchronous, active-low
//  iValid       in   1   input pixel valid
//  iSof         in   1   qualifies iPixel as pixel (0,0) of a frame
//  iPixel       in   8   input intensity
//  oReady       out  1   block can accept a pixel this cycle
//  oValid       out  1   oGrid holds a window
//  iReady       in   1   downstream accepts oGrid this cycle
//  oGrid        out  73  {tag, p8,p7,...,p0}, p[k]=oGrid[8k+7:8k]
// BEHAVIOUR
//  Grid layout
//   - p[r*3+c] = pixel(X-c, Y-2+r) for accepted pixel (X,Y).
//   - r=0 is the oldest (top) line; c=0 is the newest (rightmost) column.
//  Handshake
//   - Pixel is accepted on (iValid && oReady); oReady = !oValid || iReady.
//   - Window emitted on accepted pixel with X>=2 && Y>=2: oValid and oGrid registered the next cycle (latency 1).
//   - oValid/oGrid held stable until iReady; oValid clears on (oValid && iReady) when no new window is loaded.
//   - Back-to-back windows at one per cycle when iReady is held high.
//   - Windows per frame = (W-2)*(H-2).
//  State machine
//   - IDLE: accepted pixels with iSof=0 are consumed and dropped.
//     An accepted pixel with iSof=1 is processed as (0,0) -> ACTIVE with X=1, Y=0.
//   - ACTIVE: each accepted pixel advances X; X wraps W-1 -> 0 with Y+1.
//     The accepted pixel at (W-1,H-1) is processed, then -> IDLE.
//   - ACTIVE + accepted iSof=1: resync. The pixel is taken as (0,0) of a new frame and the partial frame is abandoned.
//     No window is emitted for that pixel; an already-pending oGrid is unaffected.
//  Datapath, per accepted pixel at column X
//   - r1 = LB1[X], r0 = LB0[X] (read-before-write).
//   - Write LB1[X] <= iPixel and LB0[X] <= r1.
//   - Window shift: col2<=col1, col1<=col0, col0<={r0, r1, iPixel} for rows 0..2.
//   - Gating on X>=2 hides line wrap-around; gating on Y>=2 hides stale line-buffer contents.
//   - Line buffers are never reset.
//  Widths
//   - X counter $clog2(IMG_WIDTH), Y counter $clog2(IMG_HEIGHT).
//   - No pixel arithmetic.
//  Reset (n_rst=0 at clk edge)
//   - oValid=0, oGrid=0, state IDLE, X=Y=0; oReady=1 after reset.
//   - Reset mid-frame discards the frame and any pending window.
// CONFIGURATION
//  WINDOW_TAG_EN defined
//   - oGrid[72]=1 on the window whose centre is (W-2,H-2), i.e. the last window of a frame.
//   - oGrid[72]=0 on every other window.
//  WINDOW_TAG_EN undefined
//   - oGrid[72] tied 0.
// STRUCTURE
//  Package grid_pkg: PIX_W=8, GRID_W=73, NTAPS=9.
//  Package grid_pkg: typedef pix_t (logic [7:0]) and grid_t (logic [72:0]).
//  Package grid_pkg: state enum {IDLE, ACTIVE}.
//  Sub-module line_buffer: depth IMG_WIDTH x 8.
//   - Combinational read at addr and write at the same addr on the clock edge (read-before-write).
//   - Instantiated twice (LB0, LB1).
// TESTING
//  W=4,H=4, pixel=16*Y+X, iReady=1
//   -> 4 windows, centres (1,1),(2,1),(1,2),(2,2).
//   -> First window: p0=02 p1=01 p2=00 p3=12 p4=11 p5=10 p6=22 p7=21 p8=20.
//  Same stream with iReady=0 for 3 cycles after the first oValid
//   -> oGrid and oValid stable, oReady=0, no pixel lost, remaining 3 windows unchanged.
//  Send 5 pixels with iSof=0, then the frame
//   -> leading pixels dropped, output identical to the first scenario.
//  iSof reasserted at (2,2) of frame A, then a full frame B (pixel=0x80+16*Y+X)
//   -> only frame B windows after resync, first p0=82 ... p8=A0.
//  WINDOW_TAG_EN defined
//   -> oGrid[72]=1 only on the 4th window (centre 2,2); undefined -> always 0.
//  n_rst=0 mid-frame with oValid=1
//   -> next cycle oValid=0, oGrid=0, oReady=1.
//   -> Subsequent full frame yields exactly 4 correct windows.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types and widths for the 3x3 grid window generator.
// Used by grid_window_gen and line_buffer.
package grid_pkg;

  localparam int PIX_W  = 8;
  localparam int GRID_W = 73;
  localparam int NTAPS  = 9;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [GRID_W-1:0] grid_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage.
// Read is combinational; the write lands on the clock edge at the same address.
module line_buffer
  import grid_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  pix_t                     wdata_i,
  output pix_t                     rdata_o
);

  pix_t mem [DEPTH];

  assign rdata_o = mem[addr_i];

  // NOTE: the storage has no reset; stale contents are masked downstream by the Y>=2 gating.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/grid_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows, one per interior pixel.
// Optional WINDOW_TAG_EN marks the last window of each frame on oGrid[72].
module grid_window_gen
  import grid_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        iValid,
  input  logic        iSof,
  input  logic [7:0]  iPixel,
  output logic        oReady,
  output logic        oValid,
  input  logic        iReady,
  output logic [72:0] oGrid
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d, px_x;
  logic [YW-1:0]     y_q, y_d, px_y;
  logic [2:0][7:0]   col0_q, col1_q, cur_col;
  logic              valid_q;
  grid_t             grid_q, grid_d;
  logic              accept, process, emit, tag;
  pix_t              r0, r1;

  assign oReady  = !valid_q || iReady;
  assign accept  = iValid && oReady;
  // A start-of-frame pixel always restarts at (0,0), whatever the current position.
  assign process = accept && (iSof || state_q == ACTIVE);
  assign px_x    = iSof ? '0 : x_q;
  assign px_y    = iSof ? '0 : y_q;
  assign emit    = process && px_x >= XW'(2) && px_y >= YW'(2);
  assign cur_col = {iPixel, r1, r0};

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .we_i    (process),
    .addr_i  (px_x),
    .wdata_i (iPixel),
    .rdata_o (r1)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk     (clk),
    .we_i    (process),
    .addr_i  (px_x),
    .wdata_i (r1),
    .rdata_o (r0)
  );

`ifdef WINDOW_TAG_EN
  assign tag = (px_x == X_LAST) && (px_y == Y_LAST);
`else
  assign tag = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (process) begin
      state_d = ACTIVE;
      if (px_x == X_LAST) begin
        x_d = '0;
        if (px_y == Y_LAST) begin
          y_d     = '0;
          state_d = IDLE;
        end else begin
          y_d = px_y + YW'(1);
        end
      end else begin
        x_d = px_x + XW'(1);
        y_d = px_y;
      end
    end
  end

  always_comb begin
    grid_d = '0;
    for (int r = 0; r < 3; r++) begin
      grid_d[PIX_W*(3*r)   +: PIX_W] = cur_col[r];
      grid_d[PIX_W*(3*r+1) +: PIX_W] = col0_q[r];
      grid_d[PIX_W*(3*r+2) +: PIX_W] = col1_q[r];
    end
    grid_d[GRID_W-1] = tag;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      col0_q  <= '0;
      col1_q  <= '0;
      valid_q <= 1'b0;
      grid_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (process) begin
        col1_q <= col0_q;
        col0_q <= cur_col;
      end
      if (emit) begin
        valid_q <= 1'b1;
        grid_q  <= grid_d;
      end else if (iReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign oValid = valid_q;
  assign oGrid  = grid_q;

endmodule

// File: tb/tb_grid_window_gen.sv
// Scoreboard bench for grid_window_gen on a 4x4 image.
module tb_grid_window_gen;
  import grid_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        n_rst, iValid, iSof, oReady, oValid, iReady;
  logic [7:0]  iPixel;
  logic [72:0] oGrid;

  int    checks   = 0;
  int    failures = 0;
  int    win_cnt  = 0;
  grid_t exp_q[$];

  grid_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .iValid (iValid),
    .iSof   (iSof),
    .iPixel (iPixel),
    .oReady (oReady),
    .oValid (oValid),
    .iReady (iReady),
    .oGrid  (oGrid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic grid_t win(input int base, input int x, input int y);
    grid_t g = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[8*(r*3+c) +: 8] = 8'(base + 16*(y-2+r) + (x-c));
`ifdef WINDOW_TAG_EN
    g[72] = (x == W-1) && (y == H-1);
`endif
    return g;
  endfunction

  // Monitor: a transfer happens at the next rising edge when oValid && iReady.
  always @(negedge clk) begin
    if (n_rst && oValid && iReady) begin
      win_cnt++;
      if (exp_q.size() == 0) check("unexpected_window", oGrid, '0 ^ {73{1'b1}} ^ oGrid ^ {73{1'b1}} ^ 73'h1);
      else check("window", oGrid, exp_q.pop_front());
    end
  end

  task automatic send_pixel(input logic [7:0] pix, input logic sof);
    int n = 0;
    iValid = 1'b1;
    iPixel = pix;
    iSof   = sof;
    @(negedge clk);
    while (!oReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!oReady) check("accept_timeout", 73'(oReady), 73'd1);
    @(posedge clk);
    #1;
    iValid = 1'b0;
    iSof   = 1'b0;
  endtask

  // Sends the first npix pixels of a frame; the first window may be a literal.
  task automatic send_frame(input int base, input int npix, input bit use_lit, input grid_t lit);
    bit first = 1'b1;
    for (int i = 0; i < npix; i++) begin
      int x = i % W;
      int y = i / W;
      if (x >= 2 && y >= 2) begin
        exp_q.push_back((first && use_lit) ? lit : win(base, x, y));
        first = 1'b0;
      end
      send_pixel(8'(base + 16*y + x), (i == 0));
    end
  endtask

  task automatic drain(input string name, input int start_cnt, input int req_cnt);
    int n = 0;
    while ((exp_q.size() != 0 || oValid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, 73'(exp_q.size()), 73'd0);
    check({name, "_count"}, 73'(win_cnt - start_cnt), 73'(req_cnt));
  endtask

  task automatic stall_after_first;
    int    n = 0;
    grid_t held;
    while (!oValid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_wait_valid", 73'(oValid), 73'd1);
    iReady = 1'b0;
    held   = oGrid;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 73'(oValid), 73'd1);
      check("stall_grid", oGrid, held);
      check("stall_ready", 73'(oReady), 73'd0);
    end
    @(posedge clk);
    #1;
    iReady = 1'b1;
  endtask

  grid_t lit_a, lit_b;
  int    start;

  initial begin
    lit_a  = {1'b0, 72'h20_21_22_10_11_12_00_01_02};
    lit_b  = {1'b0, 72'hA0_A1_A2_90_91_92_80_81_82};
    n_rst  = 1'b0;
    iValid = 1'b0;
    iSof   = 1'b0;
    iPixel = '0;
    iReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 73'(oValid), 73'd0);
    check("reset_grid",  oGrid, '0);
    check("reset_ready", 73'(oReady), 73'd1);
    n_rst = 1'b1;

    // Plain frame, downstream always ready.
    start = win_cnt;
    send_frame(0, W*H, 1'b1, lit_a);
    drain("basic", start, 4);

    // Same frame with a 3-cycle stall after the first window.
    start = win_cnt;
    fork
      send_frame(0, W*H, 1'b1, lit_a);
      stall_after_first();
    join
    drain("stall", start, 4);

    // Leading non-SOF pixels are dropped.
    start = win_cnt;
    for (int i = 0; i < 5; i++) send_pixel(8'(8'h55 + i), 1'b0);
    send_frame(0, W*H, 1'b1, lit_a);
    drain("drop", start, 4);

    // Resync: frame A abandoned just before (2,2), then frame B.
    start = win_cnt;
    send_frame(0, 2*W + 2, 1'b0, '0);
    send_frame(8'h80, W*H, 1'b1, lit_b);
    drain("resync", start, 4);

    // Reset with a window pending.
    iReady = 1'b0;
    send_frame(0, 2*W + 3, 1'b0, '0);
    @(negedge clk);
    check("pre_reset_valid", 73'(oValid), 73'd1);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_valid", 73'(oValid), 73'd0);
    check("mid_reset_grid",  oGrid, '0);
    check("mid_reset_ready", 73'(oReady), 73'd1);
    exp_q.delete();
    n_rst  = 1'b1;
    iReady = 1'b1;
    start  = win_cnt;
    send_frame(0, W*H, 1'b1, lit_a);
    drain("post_reset", start, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
